// File: rtl/pulse_gen_pkg.sv
// Shared state encoding and default widths for the pulse_gen block.
package pulse_gen_pkg;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_PEND_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pulseState_e;

endpackage

// File: rtl/pulse_gen.sv
// Triggered pulse generator: programmable high/low phase lengths, optional trigger queue.
// Define PULSE_GEN_PENDING_EN to queue triggers that arrive while a pulse is in flight.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_i,
    input  logic [CNT_W-1:0]  high_len_i,
    input  logic [CNT_W-1:0]  low_len_i,
    output logic              d_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic [PEND_W-1:0] pend_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pulseState_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lowLen_q, lowLen_d;
    logic [CNT_W-1:0] highLenFix, lowLenFix;
    logic             d_q;
    logic             overrun_q, overrun_d;
    logic             lastLow, trigBusy, replay;

    // A programmed length of zero still yields a one-cycle phase.
    assign highLenFix = (high_len_i == '0) ? CNT_ONE : high_len_i;
    assign lowLenFix  = (low_len_i  == '0) ? CNT_ONE : low_len_i;
    assign lastLow    = (state_q == LOW) && (cnt_q == CNT_ONE);
    assign trigBusy   = trig_i && (state_q != IDLE);

`ifdef PULSE_GEN_PENDING_EN
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_q, pend_d;

    // A trigger landing on the last LOW cycle chains straight into the next pulse.
    assign replay = lastLow && ((pend_q != '0) || trig_i);

    always_comb begin
        pend_d    = pend_q;
        overrun_d = 1'b0;
        if (trigBusy && !replay) begin
            if (pend_q == PEND_MAX) begin
                overrun_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (replay && !trigBusy) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
`else
    assign replay    = 1'b0;
    assign overrun_d = trigBusy;
    assign pend_o    = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lowLen_q  <= '0;
            d_q       <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lowLen_q  <= lowLen_d;
            d_q       <= (state_d == HIGH);
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lowLen_d = lowLen_q;
        unique case (state_q)
            IDLE: begin
                if (trig_i) begin
                    state_d  = HIGH;
                    cnt_d    = highLenFix;
                    lowLen_d = lowLenFix;
                end
            end
            HIGH: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = LOW;
                    cnt_d   = lowLen_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            LOW: begin
                if (lastLow) begin
                    if (replay) begin
                        state_d  = HIGH;
                        cnt_d    = highLenFix;
                        lowLen_d = lowLenFix;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        d_o       = d_q;
        busy_o    = (state_q != IDLE);
        done_o    = lastLow;
        overrun_o = overrun_q;
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: directed scenarios plus random traffic vs. a pulse-schedule model.
module tb_pulse_gen;

    localparam int TB_CNT_W  = 8;
    localparam int TB_PEND_W = 2;
    localparam int PEND_MAX  = (1 << TB_PEND_W) - 1;

    logic                 clk;
    logic                 rst_n;
    logic                 trig_i;
    logic [TB_CNT_W-1:0]  high_len_i;
    logic [TB_CNT_W-1:0]  low_len_i;
    logic                 d_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 overrun_o;
    logic [TB_PEND_W-1:0] pend_o;

    int compared   = 0;
    int mismatched = 0;

    // Model: each pulse is a window [pStart, pEnd] with HIGH covering [pStart, hEnd].
    int   now    = 0;
    int   pStart = 0;
    int   hEnd   = -1;
    int   pEnd   = -1;
    int   mPend  = 0;
    logic expD, expBusy, expDone, expOvr;
    logic [TB_PEND_W-1:0] expPend;

    int highSeen = 0;
    int doneSeen = 0;

    pulse_gen #(
        .CNT_W  (TB_CNT_W),
        .PEND_W (TB_PEND_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_i     (trig_i),
        .high_len_i (high_len_i),
        .low_len_i  (low_len_i),
        .d_o        (d_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overrun_o  (overrun_o),
        .pend_o     (pend_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic startPulse(input int h, input int l);
        pStart = now + 1;
        hEnd   = now + h;
        pEnd   = now + h + l;
    endtask

    task automatic modelStep(input logic trig, input int h, input int l, input logic rstn);
        int  hh;
        int  ll;
        bit  busyNow;
        bit  lastLow;
        bit  replay;
        hh      = (h == 0) ? 1 : h;
        ll      = (l == 0) ? 1 : l;
        busyNow = (now >= pStart) && (now <= pEnd);
        lastLow = busyNow && (now == pEnd);
        replay  = 1'b0;
        expOvr  = 1'b0;
        if (!rstn) begin
            pStart = 0;
            hEnd   = -1;
            pEnd   = -1;
            mPend  = 0;
        end else if (!busyNow) begin
            if (trig) startPulse(hh, ll);
        end else begin
`ifdef PULSE_GEN_PENDING_EN
            replay = lastLow && ((mPend > 0) || trig);
            if (trig && !replay) begin
                if (mPend < PEND_MAX) mPend++;
                else expOvr = 1'b1;
            end else if (replay && !trig) begin
                mPend--;
            end
            if (replay) startPulse(hh, ll);
`else
            if (trig) expOvr = 1'b1;
`endif
        end
        now++;
        expD    = (now >= pStart) && (now <= hEnd);
        expBusy = (now >= pStart) && (now <= pEnd);
        expDone = expBusy && (now == pEnd);
        expPend = TB_PEND_W'(mPend);
    endtask

    task automatic checkOutput();
        compared++;
        assert (d_o === expD) else begin
            mismatched++;
            $error("[TB] FAIL d_o cycle %0d: observed %b expected %b", now, d_o, expD);
        end
        compared++;
        assert (busy_o === expBusy) else begin
            mismatched++;
            $error("[TB] FAIL busy_o cycle %0d: observed %b expected %b", now, busy_o, expBusy);
        end
        compared++;
        assert (done_o === expDone) else begin
            mismatched++;
            $error("[TB] FAIL done_o cycle %0d: observed %b expected %b", now, done_o, expDone);
        end
        compared++;
        assert (overrun_o === expOvr) else begin
            mismatched++;
            $error("[TB] FAIL overrun_o cycle %0d: observed %b expected %b", now, overrun_o, expOvr);
        end
        compared++;
        assert (pend_o === expPend) else begin
            mismatched++;
            $error("[TB] FAIL pend_o cycle %0d: observed %0d expected %0d", now, pend_o, expPend);
        end
        if (d_o === 1'b1) highSeen++;
        if (done_o === 1'b1) doneSeen++;
    endtask

    task automatic applyStimulus(input logic trig, input int h, input int l, input logic rstn);
        trig_i     = trig;
        high_len_i = TB_CNT_W'(h);
        low_len_i  = TB_CNT_W'(l);
        rst_n      = rstn;
        modelStep(trig, h, l, rstn);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        trig_i     = 1'b0;
        high_len_i = '0;
        low_len_i  = '0;
        rst_n      = 1'b0;

        // Reset with a trigger held high: trigger must be ignored.
        applyStimulus(1'b1, 3, 2, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0);
        idleCycles(2);

        // Single pulse, high=3 low=2: three high cycles and one done pulse.
        highSeen = 0;
        doneSeen = 0;
        applyStimulus(1'b1, 3, 2, 1'b1);
        idleCycles(7);
        compared++;
        assert (highSeen == 3) else begin
            mismatched++;
            $error("[TB] FAIL high3_count: observed %0d expected 3", highSeen);
        end
        compared++;
        assert (doneSeen == 1) else begin
            mismatched++;
            $error("[TB] FAIL done_count: observed %0d expected 1", doneSeen);
        end

        // Zero lengths behave as one.
        highSeen = 0;
        applyStimulus(1'b1, 0, 0, 1'b1);
        idleCycles(4);
        compared++;
        assert (highSeen == 1) else begin
            mismatched++;
            $error("[TB] FAIL zero_len_high: observed %0d expected 1", highSeen);
        end

        // Three extra triggers during the first pulse.
        applyStimulus(1'b1, 2, 2, 1'b1);
        applyStimulus(1'b1, 2, 2, 1'b1);
        applyStimulus(1'b1, 2, 2, 1'b1);
        applyStimulus(1'b1, 2, 2, 1'b1);
        idleCycles(20);

        // Continuous triggers while busy drive the queue into saturation.
        applyStimulus(1'b1, 3, 3, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3, 3, 1'b1);
        idleCycles(30);

        // Trigger exactly on the last LOW cycle of a 2/2 pulse.
        applyStimulus(1'b1, 2, 2, 1'b1);
        idleCycles(3);
        applyStimulus(1'b1, 1, 1, 1'b1);
        idleCycles(8);

        // Reset mid-HIGH with queued triggers, then a fresh trigger.
        applyStimulus(1'b1, 5, 2, 1'b1);
        applyStimulus(1'b1, 5, 2, 1'b1);
        applyStimulus(1'b1, 5, 2, 1'b1);
        applyStimulus(1'b0, 5, 2, 1'b0);
        applyStimulus(1'b1, 2, 1, 1'b1);
        idleCycles(6);

        // Random traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                          ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
        end
        idleCycles(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, which sets the width of the high/low length inputs and of the internal phase counter.
REQ-002 The module SHALL have parameter PEND_W, default 4, which sets the width of the pending-trigger counter.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-005 Port trig_i, input, 1 bit, SHALL be the trigger request, sampled every cycle; each high cycle counts as one request.
REQ-006 Port high_len_i, input, CNT_W bits, SHALL give the high-phase length in cycles.
REQ-007 Port low_len_i, input, CNT_W bits, SHALL give the low-phase (gap) length in cycles.
REQ-008 Port d_o, output, 1 bit, SHALL be the generated waveform, registered.
REQ-009 Port busy_o, output, 1 bit, SHALL be high whenever the FSM is not IDLE.
REQ-010 Port done_o, output, 1 bit, SHALL be a one-cycle pulse marking completion of each pulse's low phase.
REQ-011 Port overrun_o, output, 1 bit, SHALL be a one-cycle pulse marking a dropped trigger.
REQ-012 Port pend_o, output, PEND_W bits, SHALL give the number of queued triggers.

Function
REQ-013 The FSM SHALL have states IDLE, HIGH and LOW; d_o SHALL be 1 only in HIGH.
REQ-014 In IDLE, trig_i=1 SHALL be accepted: the FSM enters HIGH and d_o rises in the next cycle (latency 1).
REQ-015 high_len_i and low_len_i SHALL be captured at the accept cycle and held for the whole pulse; a length of 0 SHALL be treated as 1.
REQ-016 HIGH SHALL last exactly the captured high length, then LOW SHALL last exactly the captured low length, using a down-counter of CNT_W bits with no wrap.
REQ-017 done_o SHALL assert for one cycle, concurrent with the last LOW cycle.
REQ-018 At the end of LOW: if pend_o>0, the FSM SHALL go directly to HIGH, decrement pend_o and capture fresh lengths in that cycle; otherwise it SHALL go to IDLE.
REQ-019 trig_i=1 while busy_o=1 SHALL increment pend_o, which saturates at 2^PEND_W-1.
REQ-020 A trigger that arrives while pend_o is saturated SHALL be dropped and SHALL pulse overrun_o in the next cycle.
REQ-021 A trigger coinciding with a pend_o decrement (REQ-018) SHALL leave pend_o unchanged and SHALL never overrun.
REQ-022 A trigger in the last LOW cycle with pend_o=0 SHALL be queued and replayed back-to-back, giving no IDLE cycle.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force state IDLE, d_o=0, busy_o=0, done_o=0, overrun_o=0, pend_o=0 and counters=0, regardless of the current phase.
REQ-024 A trigger in the same cycle as reset SHALL be ignored; after reset deasserts, the first trigger SHALL be accepted with latency 1.

Configuration
REQ-025 Macro PULSE_GEN_PENDING_EN SHALL control trigger queuing: when defined, REQ-018..REQ-022 apply.
REQ-026 When PULSE_GEN_PENDING_EN is undefined, every trigger while busy_o=1 SHALL be dropped and pulse overrun_o, pend_o SHALL be tied 0, and no pending counter SHALL be synthesised.

Structure
REQ-027 A shared package pulse_gen_pkg SHALL hold the state enum (IDLE/HIGH/LOW) and the default constants for CNT_W and PEND_W.
REQ-028 The block SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-029 Reset then trig 1 cycle, high=3, low=2 -> d_o high cycles 1-3 after trig, low cycles 4-5, done_o in cycle 5, busy_o 1 for cycles 1-5.
REQ-030 high=0, low=0, single trig -> d_o high 1 cycle, low 1 cycle, done_o once.
REQ-031 PENDING_EN defined, high=2, low=2: 3 triggers during the first pulse -> pend_o reaches 3, 4 contiguous pulses, no IDLE gaps, pend_o ends at 0.
REQ-032 PENDING_EN defined, PEND_W=2: 5 triggers while busy -> pend_o saturates at 3, overrun_o pulses for the 4th and 5th triggers.
REQ-033 PENDING_EN undefined: trigger during HIGH -> overrun_o pulses, pend_o stays 0, and exactly one pulse is produced.
REQ-034 rst_n=0 mid-HIGH with pend_o=2 -> next cycle d_o=0, busy_o=0, pend_o=0, and no done_o pulse.
